lsu_mc: RTL
===========

Name: lsu_mc

Overview:
- Multi-cycle, parametrised load/store unit; successor to the single-cycle combinational-read LSU.
- Sits between the EXU/WBU pipeline and a handshaked data-memory port (SRAM/AXI-lite bridge).
- Accepts one load/store request, issues one aligned memory beat, waits a variable number of cycles for the memory, then returns sign/zero-extended load data or a store ack.
- Adds misalignment detection, error reporting, backpressure on both sides and XLEN=32/64 support.

Parameters:
- XLEN, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, address width.
- STRB_W, XLEN/8, byte-strobe width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores.
- rsp_err  out  1  misaligned, illegal funct3, or bus error.
- mem_req_valid  out  1  memory beat valid.
- mem_req_ready  in  1  memory accepts beat.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  req_addr with low log2(STRB_W) bits cleared.
- mem_wdata  out  XLEN  store data shifted to byte lane.
- mem_wstrb  out  STRB_W  byte enables; all 0 on reads.
- mem_rsp_valid  in  1  memory response (one cycle, no backpressure).
- mem_rdata  in  XLEN  raw aligned read word.
- mem_rsp_err  in  1  bus error qualifier for mem_rsp_valid.

Behaviour:
- Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_req_valid=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wstrb=0. Reset mid-transaction drops the transaction. A mem_rsp_valid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch all req fields.
  - If the request is misaligned or funct3 is illegal, go to RESP with err=1 and issue no memory beat.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, and the mem_* outputs are held stable. On mem_req_ready, go to WAIT. mem_rsp_valid in the same cycle as the REQ handshake is not legal for the memory.
- WAIT: on mem_rsp_valid, go to RESP.
  - Loads: capture the extended data.
  - Stores: rdata=0.
  - err=mem_rsp_err.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. Then go to IDLE. No new request is accepted in the same cycle (req_ready=0 outside IDLE).
- Minimum latency: 3 cycles from request accept to rsp_valid (accept, REQ, WAIT+resp in the same cycle it arrives → RESP next). A misaligned request gives rsp_valid the cycle after accept.
- funct3 meaning:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - For XLEN=64: also 011 D and 110 WU.
  - Stores use 000/001/010, and 011 if XLEN=64. Anything else is illegal → err.
- Alignment: the address must be a multiple of the access size. Byte accesses are always aligned.
- off = addr mod STRB_W.
  - Write data: mem_wstrb = size-mask << off, and mem_wdata = wdata << (8*off).
  - Read data: shifted = mem_rdata >> (8*off), then sign- or zero-extended from bit 8/16/32·size-1 to XLEN.
- On an error response rsp_rdata=0. The fields of a failed request are not written anywhere.

Test Plan:
- XLEN=32, LB addr=0x8000_0003, mem_rdata=0x80FF_1234 after 2-cycle memory delay → rsp_rdata=0xFFFF_FF80, err=0, rsp_valid exactly once.
- XLEN=32, SH addr=0x8000_0002, wdata=0x0000_BEEF → mem_wstrb=4'b1100, mem_wdata=0xBEEF_0000, mem_addr=0x8000_0000, rsp_rdata=0.
- LW addr=0x8000_0001 → no mem_req_valid, rsp_valid next cycle with err=1, rdata=0.
- Backpressure:
  - mem_req_ready held 0 for 5 cycles → mem_* stable throughout.
  - rsp_ready held 0 for 4 cycles → rsp stable, req_ready=0.
- XLEN=64:
  - LWU addr=0x...04, mem_rdata=0x8765_4321_0000_0000 → rsp_rdata=0x0000_0000_8765_4321.
  - LD with mem_rsp_err=1 → err=1, rdata=0.
- Assert rst during WAIT → all outputs at reset values immediately (asynchronous); a late mem_rsp_valid is ignored; the next request completes normally.

Source files
------------

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit. Takes one request from the pipeline and issues
// one aligned memory beat. It then waits for the memory and returns a sign- or
// zero-extended load value, or a store acknowledge. Misaligned accesses and
// illegal funct3 codes are answered with an error and never reach memory.
module lsu_mc #(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rsp_err
);

    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_wen;
    logic [2:0]        r_funct3;
    logic [OFF_W-1:0]  r_off;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_legal;
    logic              w_misaligned;
    logic              w_bad;
    logic [STRB_W-1:0] w_size_mask;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_ext;

    assign w_off = req_addr[OFF_W-1:0];
    assign w_bad = !w_legal || w_misaligned;

    // Decode the incoming request: legality of funct3 for load/store, access size mask and alignment.
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        w_size_mask  = '0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = (XLEN == 64);
            3'b100, 3'b101:         w_legal = !req_wen;
            3'b110:                 w_legal = (XLEN == 64) && !req_wen;
            default:                w_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                w_size_mask  = STRB_W'(1);
                w_misaligned = 1'b0;
            end
            2'b01: begin
                w_size_mask  = STRB_W'(3);
                w_misaligned = req_addr[0];
            end
            2'b10: begin
                w_size_mask  = STRB_W'(15);
                w_misaligned = |req_addr[1:0];
            end
            default: begin
                w_size_mask  = '1;
                w_misaligned = |req_addr[2:0];
            end
        endcase
    end

    // Bring the addressed bytes of the returned word down to bit 0 and extend them to XLEN.
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = XLEN'($signed(w_shifted[7:0]));
            3'b001:  w_ext = XLEN'($signed(w_shifted[15:0]));
            3'b010:  w_ext = XLEN'($signed(w_shifted[31:0]));
            3'b100:  w_ext = XLEN'(w_shifted[7:0]);
            3'b101:  w_ext = XLEN'(w_shifted[15:0]);
            3'b110:  w_ext = XLEN'(w_shifted[31:0]);
            default: w_ext = w_shifted;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs for the request/memory/response sequence.
    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_bad ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the request into the beat registers and the memory reply into the response registers.
    // A rejected request only touches the response registers so no beat state is disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen       <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rsp_rdata <= '0;
                        if (w_bad) begin
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_rsp_err   <= 1'b0;
                            r_wen       <= req_wen;
                            r_funct3    <= req_funct3;
                            r_off       <= w_off;
                            r_mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wdata <= req_wdata << {w_off, 3'b000};
                            r_mem_wstrb <= req_wen ? (w_size_mask << w_off) : '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rsp_err   <= mem_rsp_err;
                        r_rsp_rdata <= (r_wen || mem_rsp_err) ? '0 : w_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
